// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: default width, tap mask, checker FSM states and next-value function.
package lfsr_pkg;

    localparam int unsigned LFSR_WIDTH_DEF = 6;
    localparam int unsigned LFSR_MAX_W     = 32;
    localparam logic [LFSR_WIDTH_DEF-1:0] LFSR_TAP_MASK = 6'b110000;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } lfsr_state_e;

    // Taps sit on the two top bits of a w-bit register (x^w + x^(w-1) + 1).
    function automatic logic [LFSR_MAX_W-1:0] lfsr_tap_mask(input int unsigned w);
        return 32'd3 << (w - 32'd2);
    endfunction

    function automatic logic [LFSR_MAX_W-1:0] lfsr_next(input logic [LFSR_MAX_W-1:0] cur,
                                                         input int unsigned w);
        logic [LFSR_MAX_W-1:0] keep;
        logic                  fb;
        keep = (32'd1 << w) - 32'd1;
        fb   = ^(cur & lfsr_tap_mask(w));
        return ((cur << 1) | {{(LFSR_MAX_W-1){1'b0}}, fb}) & keep;
    endfunction

endpackage

// File: rtl/lfsr_predict.sv
// Expected-value register: load seeds it with next(seed), advance steps it along the sequence.
module lfsr_predict
    import lfsr_pkg::*;
#(
    parameter int unsigned WIDTH = LFSR_WIDTH_DEF
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic             advance_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] expected_o
);

    logic [WIDTH-1:0] exp_q;
    logic [WIDTH-1:0] exp_d;
    logic [WIDTH-1:0] src_s;

    // Load takes priority over advance; both produce the successor of their source.
    always_comb begin
        src_s = exp_q;
        exp_d = exp_q;
        if (load_i) begin
            src_s = load_val_i;
        end else begin
            src_s = exp_q;
        end
        if (load_i || advance_i) begin
            exp_d = WIDTH'(lfsr_next(LFSR_MAX_W'(src_s), WIDTH));
        end else begin
            exp_d = exp_q;
        end
    end

    // Expected-value register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            exp_q <= {WIDTH{1'b0}};
        end else begin
            exp_q <= exp_d;
        end
    end

    assign expected_o = exp_q;

endmodule

// File: rtl/lfsr_checker.sv
// LFSR sequence checker: seeds, verifies LOCK_N matches, then flags errors while locked.
// Optional full-period check enabled by defining LFSR_CHECKER_PERIOD_EN.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int unsigned WIDTH  = LFSR_WIDTH_DEF,
    parameter int unsigned LOCK_N = 4,
    parameter int unsigned ERRW   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic [WIDTH-1:0] count_to,
    output logic             locked,
    output logic             err,
    output logic [ERRW-1:0]  err_count,
    output logic             reached,
    output logic             period_ok
);

    localparam int unsigned MW = $clog2(LOCK_N + 1);

    lfsr_state_e      state_q, state_d;
    logic [MW-1:0]    match_q, match_d;
    logic [ERRW-1:0]  err_count_q, err_count_d;
    logic             locked_q, err_q, err_d, reached_q, reached_d;
    logic             load_s, advance_s, hit_s;
    logic [WIDTH-1:0] expected_s;

    lfsr_predict #(.WIDTH(WIDTH)) u_predict (
        .clk_i      (clk),
        .reset_i    (reset),
        .load_i     (load_s),
        .advance_i  (advance_s),
        .load_val_i (din),
        .expected_o (expected_s)
    );

    assign hit_s = (din == expected_s);

    // Next-state, predictor control and output pulse decode.
    always_comb begin
        state_d     = state_q;
        match_d     = match_q;
        err_count_d = err_count_q;
        load_s      = 1'b0;
        advance_s   = 1'b0;
        err_d       = 1'b0;
        reached_d   = (state_q == ST_LOCKED) && din_valid && (din == count_to);
        case (state_q)
            ST_SEARCH: begin
                if (din_valid && (din != {WIDTH{1'b0}})) begin
                    load_s  = 1'b1;
                    match_d = {MW{1'b0}};
                    state_d = ST_VERIFY;
                end else begin
                    state_d = ST_SEARCH;
                end
            end
            ST_VERIFY: begin
                if (!din_valid) begin
                    state_d = ST_VERIFY;
                end else if (hit_s) begin
                    advance_s = 1'b1;
                    if (match_q == MW'(LOCK_N - 1)) begin
                        match_d = {MW{1'b0}};
                        state_d = ST_LOCKED;
                    end else begin
                        match_d = match_q + MW'(1);
                    end
                end else if (din == {WIDTH{1'b0}}) begin
                    match_d = {MW{1'b0}};
                    state_d = ST_SEARCH;
                end else begin
                    load_s  = 1'b1;
                    match_d = {MW{1'b0}};
                end
            end
            ST_LOCKED: begin
                if (!din_valid) begin
                    state_d = ST_LOCKED;
                end else if (hit_s) begin
                    advance_s = 1'b1;
                end else begin
                    err_d   = 1'b1;
                    state_d = ST_SEARCH;
                    if (err_count_q != {ERRW{1'b1}}) begin
                        err_count_d = err_count_q + ERRW'(1);
                    end else begin
                        err_count_d = err_count_q;
                    end
                end
            end
            default: begin
                match_d = {MW{1'b0}};
                state_d = ST_SEARCH;
            end
        endcase
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_SEARCH;
            match_q     <= {MW{1'b0}};
            err_count_q <= {ERRW{1'b0}};
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
            reached_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            match_q     <= match_d;
            err_count_q <= err_count_d;
            locked_q    <= (state_d == ST_LOCKED);
            err_q       <= err_d;
            reached_q   <= reached_d;
        end
    end

    assign locked    = locked_q;
    assign err       = err_q;
    assign err_count = err_count_q;
    assign reached   = reached_q;

`ifdef LFSR_CHECKER_PERIOD_EN
    logic [WIDTH-1:0] entry_q;
    logic [WIDTH-1:0] steps_q;
    logic             period_ok_q;
    logic             lock_entry_s;
    logic             step_s;

    assign lock_entry_s = (state_q == ST_VERIFY) && (state_d == ST_LOCKED);
    assign step_s       = (state_q == ST_LOCKED) && advance_s;

    // Counts correct locked steps; a return to the lock-entry value must land on 2^WIDTH-1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entry_q     <= {WIDTH{1'b0}};
            steps_q     <= {WIDTH{1'b0}};
            period_ok_q <= 1'b0;
        end else if (lock_entry_s) begin
            entry_q <= din;
            steps_q <= {WIDTH{1'b0}};
        end else if (step_s) begin
            if (din == entry_q) begin
                period_ok_q <= (steps_q == ({WIDTH{1'b1}} - WIDTH'(1)));
                steps_q     <= {WIDTH{1'b0}};
            end else begin
                steps_q <= steps_q + WIDTH'(1);
            end
        end else if (err_d) begin
            period_ok_q <= 1'b0;
            steps_q     <= {WIDTH{1'b0}};
        end else begin
            period_ok_q <= period_ok_q;
        end
    end

    assign period_ok = period_ok_q;
`else
    assign period_ok = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Self-checking bench for lfsr_checker: directed scenarios plus randomized traffic
// compared against a sequence-position model of the checker.
module tb_lfsr_checker;

`ifdef LFSR_CHECKER_PERIOD_EN
    localparam int PERIOD_EN = 1;
`else
    localparam int PERIOD_EN = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       din_valid = 1'b0;
    logic [5:0] din = 6'd0;
    logic [5:0] count_to = 6'd0;
    logic       locked, err, reached, period_ok;
    logic [7:0] err_count;

    int n_checks = 0;
    int n_errors = 0;

    int seq [63];
    int pos [64];
    int p;

    // model: mode 0=search 1=verify 2=locked; m_idx indexes seq[] for the expected value
    int m_mode, m_idx, m_matches, m_errs, m_entry, m_steps;
    int m_pok, m_err, m_reached;

    lfsr_checker dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .din_valid (din_valid),
        .count_to  (count_to),
        .locked    (locked),
        .err       (err),
        .err_count (err_count),
        .reached   (reached),
        .period_ok (period_ok)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int expv);
        n_checks++;
        if (got != expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_idx = 0; m_matches = 0; m_errs = 0;
        m_entry = 0; m_steps = 0; m_pok = 0; m_err = 0; m_reached = 0;
    endtask

    task automatic model_step(input int v, input int d);
        m_err = 0;
        m_reached = 0;
        if (v != 0) begin
            m_reached = (m_mode == 2 && d == int'(count_to)) ? 1 : 0;
            case (m_mode)
                0: if (d != 0) begin
                    m_idx = (pos[d] + 1) % 63; m_matches = 0; m_mode = 1;
                end
                1: if (d == seq[m_idx]) begin
                    m_idx = (m_idx + 1) % 63;
                    m_matches++;
                    if (m_matches == 4) begin
                        m_mode = 2; m_entry = d; m_steps = 0;
                    end
                end else if (d == 0) begin
                    m_mode = 0;
                end else begin
                    m_idx = (pos[d] + 1) % 63; m_matches = 0;
                end
                default: if (d == seq[m_idx]) begin
                    m_idx = (m_idx + 1) % 63;
                    m_steps++;
                    if (d == m_entry) begin
                        m_pok = (m_steps == 63) ? 1 : 0;
                        m_steps = 0;
                    end
                end else begin
                    m_err = 1;
                    m_errs = (m_errs < 255) ? m_errs + 1 : 255;
                    m_mode = 0;
                    m_pok = 0;
                end
            endcase
        end
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, "_locked"}, locked, (m_mode == 2) ? 1 : 0);
        check_eq({tag, "_err"}, err, m_err);
        check_eq({tag, "_reached"}, reached, m_reached);
        check_eq({tag, "_err_count"}, err_count, m_errs);
        check_eq({tag, "_period_ok"}, period_ok, (PERIOD_EN != 0) ? m_pok : 0);
    endtask

    task automatic cycle(input logic v, input logic [5:0] d);
        din_valid = v;
        din = d;
        @(posedge clk);
        #1;
        model_step(int'(v), int'(d));
        check_all("cyc");
    endtask

    task automatic drive_seq(input int n);
        for (int k = 0; k < n; k++) begin
            cycle(1'b1, 6'(seq[p]));
            p = (p + 1) % 63;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("rst");
        @(posedge clk);
        #1;
        reset = 1'b0;
        din_valid = 1'b0;
    endtask

    initial begin
        int v;
        int found;
        v = 1;
        pos[0] = 0;
        for (int i = 0; i < 63; i++) begin
            seq[i] = v;
            pos[v] = i;
            v = ((v << 1) & 63) | (((v >> 5) ^ (v >> 4)) & 1);
        end
        model_reset();

        // asynchronous reset at start
        #1;
        reset = 1'b1;
        #1;
        check_all("init");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // lock on the documented five-sample sequence
        cycle(1'b1, 6'b001011);
        cycle(1'b1, 6'b010110);
        cycle(1'b1, 6'b101101);
        cycle(1'b1, 6'b011011);
        check_eq("lock_pre", locked, 0);
        cycle(1'b1, 6'b110111);
        check_eq("lock_rise", locked, 1);
        check_eq("lock_noerr", err, 0);
        p = (pos[55] + 1) % 63;

        // one full period after lock entry
        drive_seq(63);
        check_eq("period", period_ok, PERIOD_EN);

        // valid gaps while locked
        for (int k = 0; k < 10; k++) cycle(1'b0, 6'($urandom_range(0, 63)));
        drive_seq(1);
        check_eq("gap_locked", locked, 1);
        check_eq("gap_noerr", err, 0);

        // reached on the cycle after din == count_to
        count_to = 6'b010000;
        found = 0;
        for (int k = 0; k < 63 && found == 0; k++) begin
            v = seq[p];
            drive_seq(1);
            if (v == 16) begin
                found = 1;
                check_eq("reached_hit", reached, 1);
            end
        end
        check_eq("reached_found", found, 1);
        cycle(1'b1, 6'(seq[p]));
        p = (p + 1) % 63;
        check_eq("reached_pulse", reached, 0);

        // sequence error while locked
        if (seq[p] == 1) drive_seq(1);
        cycle(1'b1, 6'b000001);
        check_eq("err_pulse", err, 1);
        check_eq("err_cnt1", err_count, 1);
        check_eq("err_unlock", locked, 0);
        cycle(1'b0, 6'b000000);
        check_eq("err_once", err, 0);

        // build err_count to 3, lock, then reset mid-lock
        for (int k = 0; k < 2; k++) begin
            drive_seq(5);
            cycle(1'b1, 6'b000000);
        end
        drive_seq(5);
        check_eq("pre_rst_cnt", err_count, 3);
        check_eq("pre_rst_lock", locked, 1);
        apply_reset();
        drive_seq(4);
        check_eq("relock_4", locked, 0);
        drive_seq(1);
        check_eq("relock_5", locked, 1);

        // randomized traffic: mostly correct sequence, gaps, corrupt and zero samples
        for (int k = 0; k < 2000; k++) begin
            int r;
            r = $urandom_range(0, 99);
            if (k % 50 == 0) count_to = 6'(seq[$urandom_range(0, 62)]);
            if (r >= 80) begin
                cycle(1'b0, 6'($urandom_range(0, 63)));
            end else if (r < 6) begin
                cycle(1'b1, 6'($urandom_range(0, 63)));
            end else begin
                drive_seq(1);
            end
        end

        // err_count saturation
        for (int k = 0; k < 260; k++) begin
            drive_seq(5);
            cycle(1'b1, 6'b000000);
        end
        check_eq("sat", err_count, 255);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
